// File: rtl/dm_byte_lane_pkg.sv
// Shared constants for the byte-lane data memory: access sizes, FSM states
// and the alignment rule shared by the controller and the lane logic.
package dm_byte_lane_pkg;

    localparam int WORD_WIDTH_DEF = 32;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        DM_IDLE = 2'b00,
        DM_WAIT = 2'b01,
        DM_RESP = 2'b10
    } dm_state_t;

    // Size code 11 has no legal alignment, so it is reported as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = lane[0];
            SIZE_WORD: is_misaligned = (lane != 2'b00);
            default:   is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dm_byte_lane_align.sv
// Combinational lane logic: merges store data into the old word and
// extracts/extends the load value (little-endian lanes).
module dm_lane_align
    import dm_byte_lane_pkg::*;
(
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_sext,
    output logic [31:0] o_merged,
    output logic [31:0] o_load
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    function automatic logic [31:0] extend8(input logic [7:0] b, input logic sx);
        extend8 = {{24{sx & b[7]}}, b};
    endfunction

    function automatic logic [31:0] extend16(input logic [15:0] h, input logic sx);
        extend16 = {{16{sx & h[15]}}, h};
    endfunction

    always_comb begin
        w_byte   = i_old_word[{i_lane, 3'b000} +: 8];
        w_half   = i_lane[1] ? i_old_word[31:16] : i_old_word[15:0];
        o_merged = i_old_word;
        o_load   = 32'b0;
        case (i_size)
            SIZE_BYTE: begin
                o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
                o_load = extend8(w_byte, i_sext);
            end
            SIZE_HALF: begin
                if (i_lane[1]) o_merged[31:16] = i_wdata[15:0];
                else           o_merged[15:0]  = i_wdata[15:0];
                o_load = extend16(w_half, i_sext);
            end
            SIZE_WORD: begin
                o_merged = i_wdata;
                o_load   = i_old_word;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_byte_lane.sv
// Byte-addressed data memory with fixed access latency behind a req/ready
// handshake; misaligned or out-of-range accesses respond early with err.
module dm_byte_lane
    import dm_byte_lane_pkg::*;
#(
    parameter int MEM_SIZE   = 128,
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  signExt,
    input  logic [WORD_WIDTH-1:0] memAddr,
    input  logic [WORD_WIDTH-1:0] dataToWrite,
    output logic [WORD_WIDTH-1:0] outData,
    output logic                  ready,
    output logic                  err
);

    localparam int AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [WORD_WIDTH-3:0] C_WORDS = (WORD_WIDTH-2)'(MEM_SIZE);
    localparam logic [3:0] C_LAT = 4'(LATENCY);

    generate
        if (WORD_WIDTH != 32) begin : g_bad_width
            $error("dm_byte_lane: WORD_WIDTH must be 32");
        end
        if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
            $error("dm_byte_lane: LATENCY must be in 0..15");
        end
    endgenerate

    dm_state_t             r_state;
    logic [3:0]            r_cnt;
    logic                  r_ready;
    logic                  r_err;
    logic [WORD_WIDTH-1:0] r_out;

    logic                  r_we;
    logic [1:0]            r_size;
    logic                  r_sext;
    logic [AW-1:0]         r_idx;
    logic [1:0]            r_lane;
    logic [WORD_WIDTH-1:0] r_wdata;

    logic [WORD_WIDTH-1:0] r_mem [MEM_SIZE];

    logic                  w_idle;
    logic                  w_bad;
    logic                  w_commit;
    logic                  w_we;
    logic [1:0]            w_size;
    logic                  w_sext;
    logic [AW-1:0]         w_idx;
    logic [1:0]            w_lane;
    logic [WORD_WIDTH-1:0] w_wdata;
    logic [WORD_WIDTH-1:0] w_old;
    logic [WORD_WIDTH-1:0] w_merged;
    logic [WORD_WIDTH-1:0] w_load;

    assign w_idle = (r_state == DM_IDLE);
    assign w_bad  = is_misaligned(size, memAddr[1:0]) | (memAddr[WORD_WIDTH-1:2] >= C_WORDS);

    // A zero-latency access commits on the accept edge, straight from the ports.
    assign w_we    = w_idle ? we                 : r_we;
    assign w_size  = w_idle ? size               : r_size;
    assign w_sext  = w_idle ? signExt            : r_sext;
    assign w_idx   = w_idle ? memAddr[AW+1:2]    : r_idx;
    assign w_lane  = w_idle ? memAddr[1:0]       : r_lane;
    assign w_wdata = w_idle ? dataToWrite        : r_wdata;

    assign w_commit = w_idle ? (req & ~w_bad & (LATENCY == 0))
                             : ((r_state == DM_WAIT) && (r_cnt == 4'd1));

    assign w_old = r_mem[w_idx];

    dm_lane_align u_align (
        .i_old_word (w_old),
        .i_wdata    (w_wdata),
        .i_lane     (w_lane),
        .i_size     (w_size),
        .i_sext     (w_sext),
        .o_merged   (w_merged),
        .o_load     (w_load)
    );

    always_ff @(posedge clk) begin
        if (w_commit && w_we && !rst) r_mem[w_idx] <= w_merged;
    end

    always_ff @(posedge clk) begin
        if (w_idle && req) begin
            r_we    <= we;
            r_size  <= size;
            r_sext  <= signExt;
            r_idx   <= memAddr[AW+1:2];
            r_lane  <= memAddr[1:0];
            r_wdata <= dataToWrite;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DM_IDLE;
            r_cnt   <= 4'd0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_out   <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                DM_IDLE: begin
                    if (req) begin
                        if (w_bad) begin
                            r_state <= DM_RESP;
                            r_ready <= 1'b1;
                            r_err   <= 1'b1;
                            r_out   <= '0;
                        end else if (LATENCY == 0) begin
                            r_state <= DM_RESP;
                            r_ready <= 1'b1;
                            r_err   <= 1'b0;
                            r_out   <= we ? '0 : w_load;
                        end else begin
                            r_state <= DM_WAIT;
                            r_cnt   <= C_LAT;
                        end
                    end
                end
                DM_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= DM_RESP;
                        r_ready <= 1'b1;
                        r_err   <= 1'b0;
                        r_out   <= r_we ? '0 : w_load;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DM_RESP: r_state <= DM_IDLE;
                default: r_state <= DM_IDLE;
            endcase
        end
    end

    assign outData = r_out;
    assign ready   = r_ready;
    assign err     = r_err;

endmodule

// File: tb/tb_dm_byte_lane.sv
// Scoreboard bench for dm_byte_lane: one instance with LATENCY=2 and one with
// LATENCY=0; expected responses (data, err, arrival cycle) are queued at issue.
module tb_dm_byte_lane;
    import dm_byte_lane_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req2, we2, sext2, rdy2, err2;
    logic [1:0]  size2;
    logic [31:0] addr2, wd2, out2;
    logic        req0, we0, sext0, rdy0, err0;
    logic [1:0]  size0;
    logic [31:0] addr0, wd0, out0;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [31:0] cyc;
    } exp_t;

    exp_t  q2[$];
    exp_t  q0[$];
    string t2[$];
    string t0[$];

    int unsigned cyc = 0;
    int n_cmp = 0;
    int n_mis = 0;
    int pulses2 = 0;
    int pulses0 = 0;

    dm_byte_lane #(.MEM_SIZE(128), .WORD_WIDTH(32), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst), .req(req2), .we(we2), .size(size2), .signExt(sext2),
        .memAddr(addr2), .dataToWrite(wd2), .outData(out2), .ready(rdy2), .err(err2)
    );

    dm_byte_lane #(.MEM_SIZE(128), .WORD_WIDTH(32), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .size(size0), .signExt(sext0),
        .memAddr(addr0), .dataToWrite(wd0), .outData(out0), .ready(rdy0), .err(err0)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon2
        exp_t  e;
        string t;
        if (rdy2 === 1'b1) begin
            pulses2++;
            if (q2.size() == 0) chk("u2_unexpected_ready", 32'd1, 32'd0);
            else begin
                e = q2.pop_front();
                t = t2.pop_front();
                chk({t, "_data"}, out2, e.data);
                chk({t, "_err"}, 32'(err2), 32'(e.err));
                chk({t, "_cycle"}, cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin : mon0
        exp_t  e;
        string t;
        if (rdy0 === 1'b1) begin
            pulses0++;
            if (q0.size() == 0) chk("u0_unexpected_ready", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                t = t0.pop_front();
                chk({t, "_data"}, out0, e.data);
                chk({t, "_err"}, 32'(err0), 32'(e.err));
                chk({t, "_cycle"}, cyc, e.cyc);
            end
        end
    end

    task automatic push2(input string tag, input logic [31:0] d, input logic e, input logic [31:0] c);
        exp_t x;
        x.data = d; x.err = e; x.cyc = c;
        q2.push_back(x);
        t2.push_back(tag);
    endtask

    task automatic push0(input string tag, input logic [31:0] d, input logic e, input logic [31:0] c);
        exp_t x;
        x.data = d; x.err = e; x.cyc = c;
        q0.push_back(x);
        t0.push_back(tag);
    endtask

    task automatic drain2();
        int k;
        k = 0;
        while (q2.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (q2.size() != 0) begin
            chk("u2_timeout", 32'(q2.size()), 32'd0);
            q2.delete();
            t2.delete();
        end
    endtask

    task automatic drain0();
        int k;
        k = 0;
        while (q0.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (q0.size() != 0) begin
            chk("u0_timeout", 32'(q0.size()), 32'd0);
            q0.delete();
            t0.delete();
        end
    endtask

    // Valid accesses answer LATENCY+1 edges after accept; errors after one.
    task automatic acc2(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_d, input logic exp_e);
        @(negedge clk);
        we2 = w; size2 = sz; sext2 = sx; addr2 = a; wd2 = d; req2 = 1'b1;
        push2(tag, exp_d, exp_e, cyc + 1 + (exp_e ? 0 : 2));
        @(negedge clk);
        req2 = 1'b0;
        drain2();
    endtask

    task automatic acc0(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_d, input logic exp_e);
        @(negedge clk);
        we0 = w; size0 = sz; sext0 = sx; addr0 = a; wd0 = d; req0 = 1'b1;
        push0(tag, exp_d, exp_e, cyc + 1);
        @(negedge clk);
        req0 = 1'b0;
        drain0();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles expected fewer", cyc);
        $fatal(1);
    end

    initial begin : stim
        int p;
        rst = 1'b1;
        req2 = 1'b0; we2 = 1'b0; sext2 = 1'b0; size2 = SIZE_WORD; addr2 = '0; wd2 = '0;
        req0 = 1'b0; we0 = 1'b0; sext0 = 1'b0; size0 = SIZE_WORD; addr0 = '0; wd0 = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready2", 32'(rdy2), 32'd0);
        chk("rst_err2",   32'(err2), 32'd0);
        chk("rst_out2",   out2,      32'd0);
        chk("rst_ready0", 32'(rdy0), 32'd0);
        chk("rst_err0",   32'(err0), 32'd0);
        chk("rst_out0",   out0,      32'd0);

        // Requests raised while reset is held must not be accepted.
        req2 = 1'b1; req0 = 1'b1;
        @(negedge clk);
        rst = 1'b0; req2 = 1'b0; req0 = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_req_no_accept", 32'(pulses2 + pulses0), 32'd0);

        acc2("sw_8",    1'b1, SIZE_WORD, 1'b0, 32'h8, 32'h11223344, 32'h0,        1'b0);
        acc2("lw_8",    1'b0, SIZE_WORD, 1'b0, 32'h8, 32'h0,        32'h11223344, 1'b0);
        acc2("lb_9",    1'b0, SIZE_BYTE, 1'b1, 32'h9, 32'h0,        32'h00000033, 1'b0);
        acc2("lhu_a",   1'b0, SIZE_HALF, 1'b0, 32'hA, 32'h0,        32'h00001122, 1'b0);
        acc2("lh_8",    1'b0, SIZE_HALF, 1'b1, 32'h8, 32'h0,        32'h00003344, 1'b0);
        acc2("sb_b",    1'b1, SIZE_BYTE, 1'b0, 32'hB, 32'hFFFFFF80, 32'h0,        1'b0);
        acc2("lb_b",    1'b0, SIZE_BYTE, 1'b1, 32'hB, 32'h0,        32'hFFFFFF80, 1'b0);
        acc2("lbu_b",   1'b0, SIZE_BYTE, 1'b0, 32'hB, 32'h0,        32'h00000080, 1'b0);
        acc2("lw_8b",   1'b0, SIZE_WORD, 1'b0, 32'h8, 32'h0,        32'h80223344, 1'b0);
        acc2("sh_a",    1'b1, SIZE_HALF, 1'b0, 32'hA, 32'h1234BEEF, 32'h0,        1'b0);
        acc2("lh_a",    1'b0, SIZE_HALF, 1'b1, 32'hA, 32'h0,        32'hFFFFBEEF, 1'b0);
        acc2("lw_8sx",  1'b0, SIZE_WORD, 1'b1, 32'h8, 32'h0,        32'hBEEF3344, 1'b0);

        acc2("sw_4",    1'b1, SIZE_WORD, 1'b0, 32'h4,   32'h55667788, 32'h0, 1'b0);
        acc2("lw_6",    1'b0, SIZE_WORD, 1'b0, 32'h6,   32'h0,        32'h0, 1'b1);
        acc2("sh_5",    1'b1, SIZE_HALF, 1'b0, 32'h5,   32'h0000FFFF, 32'h0, 1'b1);
        acc2("lw_200",  1'b0, SIZE_WORD, 1'b0, 32'h200, 32'h0,        32'h0, 1'b1);
        acc2("sz11_4",  1'b1, 2'b11,     1'b0, 32'h4,   32'hFFFFFFFF, 32'h0, 1'b1);
        acc2("sb_200",  1'b1, SIZE_BYTE, 1'b0, 32'h200, 32'hFF,       32'h0, 1'b1);
        acc2("lw_4",    1'b0, SIZE_WORD, 1'b0, 32'h4,   32'h0, 32'h55667788, 1'b0);

        acc2("sw_1fc",  1'b1, SIZE_WORD, 1'b0, 32'h1FC, 32'hCAFEF00D, 32'h0, 1'b0);
        acc2("lw_1fc",  1'b0, SIZE_WORD, 1'b0, 32'h1FC, 32'h0, 32'hCAFEF00D, 1'b0);
        acc2("lbu_1ff", 1'b0, SIZE_BYTE, 1'b0, 32'h1FF, 32'h0, 32'h000000CA, 1'b0);

        acc2("sw_10",   1'b1, SIZE_WORD, 1'b0, 32'h10, 32'h0BADF00D, 32'h0, 1'b0);
        acc2("lw_10a",  1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 32'h0BADF00D, 1'b0);
        p = pulses2;
        @(negedge clk);
        we2 = 1'b1; size2 = SIZE_WORD; sext2 = 1'b0; addr2 = 32'h10; wd2 = 32'hDEADBEEF; req2 = 1'b1;
        @(negedge clk);
        req2 = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_wait_no_ready", 32'(pulses2 - p), 32'd0);
        acc2("lw_10b",  1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 32'h0BADF00D, 1'b0);

        // Zero latency, req held: responses every second cycle, none doubled.
        @(negedge clk);
        we0 = 1'b1; size0 = SIZE_WORD; sext0 = 1'b0; addr0 = 32'h0; wd0 = 32'hA5A5A5A5; req0 = 1'b1;
        push0("b2b_sw", 32'h0, 1'b0, cyc + 1);
        @(negedge clk);
        we0 = 1'b0;
        push0("b2b_lw1", 32'hA5A5A5A5, 1'b0, cyc + 2);
        repeat (2) @(negedge clk);
        push0("b2b_lw2", 32'hA5A5A5A5, 1'b0, cyc + 2);
        repeat (2) @(negedge clk);
        req0 = 1'b0;
        drain0();
        repeat (3) @(negedge clk);

        acc0("l0_sb_3",  1'b1, SIZE_BYTE, 1'b0, 32'h3,   32'h000000F0, 32'h0,        1'b0);
        acc0("l0_lb_3",  1'b0, SIZE_BYTE, 1'b1, 32'h3,   32'h0,        32'hFFFFFFF0, 1'b0);
        acc0("l0_lw_0",  1'b0, SIZE_WORD, 1'b0, 32'h0,   32'h0,        32'hF0A5A5A5, 1'b0);
        acc0("l0_lw_200",1'b0, SIZE_WORD, 1'b0, 32'h200, 32'h0,        32'h0,        1'b1);
        acc0("l0_lhu_2", 1'b0, SIZE_HALF, 1'b0, 32'h2,   32'h0,        32'h0000F0A5, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
